// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if
//   Request/response bundle between the execute stage and the multi-cycle
//   multiply/divide sequencer.
//   master (execute stage): drives start, flush, alucode, op1, op2, rd_in;
//                           observes ready, busy, result_valid, result, rd_out.
//   slave  (muldiv_seq)   : the reverse directions.
interface muldiv_seq_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic            flush;
    logic [5:0]      alucode;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [4:0]      rd_in;
    logic            ready;
    logic            busy;
    logic            result_valid;
    logic [XLEN-1:0] result;
    logic [4:0]      rd_out;

    modport master (
        output start, flush, alucode, op1, op2, rd_in,
        input  ready, busy, result_valid, result, rd_out
    );

    modport slave (
        input  start, flush, alucode, op1, op2, rd_in,
        output ready, busy, result_valid, result, rd_out
    );
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Multi-cycle sequencer for the RV32M multiply/divide operations. Accepts
//   one operation, runs XLEN iterations of a shared shift-add / restoring
//   subtract datapath on operand magnitudes, applies sign correction and
//   returns the result tagged with its destination register.
//   Ports:
//     clk    - clock, rising edge
//     rst_n  - synchronous active-low reset
//     bus    - muldiv_seq_if.slave: start/flush/alucode/op1/op2/rd_in in,
//              ready/busy/result_valid/result/rd_out out
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_seq_if.slave  bus
);
    // Operation codes, matching the ALU_* encoding of define.vh.
    localparam logic [5:0] ALU_MUL    = 6'd28;
    localparam logic [5:0] ALU_MULH   = 6'd29;
    localparam logic [5:0] ALU_MULHSU = 6'd30;
    localparam logic [5:0] ALU_MULHU  = 6'd31;
    localparam logic [5:0] ALU_DIV    = 6'd32;
    localparam logic [5:0] ALU_DIVU   = 6'd33;
    localparam logic [5:0] ALU_REM    = 6'd34;
    localparam logic [5:0] ALU_REMU   = 6'd35;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam int              CNTW = $clog2(XLEN);
    localparam logic [CNTW-1:0] LAST = CNTW'(XLEN - 1);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state;
    logic [CNTW-1:0] cnt;
    logic [5:0]      op_q;
    logic            div_q;
    logic            neg_q;
    logic [XLEN-1:0] m_q;      // multiplicand (mul) or divisor (div)
    logic [XLEN-1:0] hi_q;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q;     // multiplier being shifted out / quotient
    logic [4:0]      tag_q;
    logic [XLEN-1:0] result_q;
    logic [4:0]      rd_q;
    logic            valid_q;

    // Operation decode on the incoming request
    logic            is_md, is_div, a_sgn, b_sgn;
    logic            a_neg, b_neg, neg_in;
    logic [XLEN-1:0] abs_a, abs_b;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] spec_res;

    always_comb begin
        is_md  = 1'b0;
        is_div = 1'b0;
        a_sgn  = 1'b0;
        b_sgn  = 1'b0;
        case (bus.alucode)
            ALU_MUL, ALU_MULH: begin
                is_md = 1'b1;
                a_sgn = 1'b1;
                b_sgn = 1'b1;
            end
            ALU_MULHSU: begin
                is_md = 1'b1;
                a_sgn = 1'b1;
            end
            ALU_MULHU: is_md = 1'b1;
            ALU_DIV, ALU_REM: begin
                is_md  = 1'b1;
                is_div = 1'b1;
                a_sgn  = 1'b1;
                b_sgn  = 1'b1;
            end
            ALU_DIVU, ALU_REMU: begin
                is_md  = 1'b1;
                is_div = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        a_neg  = a_sgn & bus.op1[XLEN-1];
        b_neg  = b_sgn & bus.op2[XLEN-1];
        abs_a  = a_neg ? -bus.op1 : bus.op1;
        abs_b  = b_neg ? -bus.op2 : bus.op2;
        // Remainder follows the dividend sign; everything else follows the
        // sign disagreement of the two operands.
        neg_in = (bus.alucode == ALU_REM) ? a_neg : (a_neg ^ b_neg);

        div_zero = is_div && (bus.op2 == '0);
        div_ovf  = is_div && a_sgn && (bus.op1 == SMIN) && (bus.op2 == '1);
        special  = div_zero || div_ovf;

        if (div_zero)
            spec_res = (bus.alucode == ALU_DIV || bus.alucode == ALU_DIVU) ? '1 : bus.op1;
        else
            spec_res = (bus.alucode == ALU_REM) ? '0 : SMIN;
    end

    // One iteration of the shared datapath
    logic [XLEN:0]   msum;
    logic [XLEN:0]   dshift;
    logic [XLEN:0]   ddiff;
    logic [XLEN-1:0] step_hi, step_lo;

    always_comb begin
        msum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        dshift = {hi_q, lo_q[XLEN-1]};
        // Partial remainder stays below the divisor, so bit XLEN of the
        // difference is exactly the borrow.
        ddiff  = dshift - {1'b0, m_q};
        if (div_q) begin
            step_hi = ddiff[XLEN] ? dshift[XLEN-1:0] : ddiff[XLEN-1:0];
            step_lo = {lo_q[XLEN-2:0], ~ddiff[XLEN]};
        end else begin
            step_hi = msum[XLEN:1];
            step_lo = {msum[0], lo_q[XLEN-1:1]};
        end
    end

    // Sign correction and result selection
    logic [2*XLEN-1:0] prod_s;
    logic [XLEN-1:0]   quo_s, rem_s, fix_res;

    always_comb begin
        prod_s = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        quo_s  = neg_q ? -lo_q : lo_q;
        rem_s  = neg_q ? -hi_q : hi_q;
        if (div_q)
            fix_res = (op_q == ALU_DIV || op_q == ALU_DIVU) ? quo_s : rem_s;
        else
            fix_res = (op_q == ALU_MUL) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            op_q     <= '0;
            div_q    <= 1'b0;
            neg_q    <= 1'b0;
            m_q      <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            tag_q    <= '0;
            result_q <= '0;
            rd_q     <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.flush && is_md) begin
                        op_q  <= bus.alucode;
                        div_q <= is_div;
                        neg_q <= neg_in;
                        tag_q <= bus.rd_in;
                        cnt   <= '0;
                        if (special) begin
                            result_q <= spec_res;
                            rd_q     <= bus.rd_in;
                            valid_q  <= 1'b1;
                            state    <= DONE;
                        end else begin
                            hi_q  <= '0;
                            lo_q  <= is_div ? abs_a : abs_b;
                            m_q   <= is_div ? abs_b : abs_a;
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        hi_q <= step_hi;
                        lo_q <= step_lo;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST)
                            state <= FIX;
                    end
                end
                FIX: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        result_q <= fix_res;
                        rd_q     <= tag_q;
                        valid_q  <= 1'b1;
                        state    <= DONE;
                    end
                end
                default: state <= IDLE;  // DONE
            endcase
        end
    end

    assign bus.ready        = (state == IDLE);
    assign bus.busy         = (state != IDLE);
    assign bus.result_valid = valid_q;
    assign bus.result       = result_q;
    assign bus.rd_out       = rd_q;
endmodule
